seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Snoops a multiplexed, active-low 7-segment display bus: seg[6:0] in abcdefg order plus per-digit anode enables.
- Decodes each stable digit pattern back to BCD and assembles one full scan frame of DIGITS digits.
- Publishes the frame as a BCD word with a one-cycle valid pulse.
- Sits beside the display driver as a loopback checker, i.e. the receive end of the BCD-to-segment encoding.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive unchanged samples required before a pattern is accepted (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg  input  7  segment lines, active low; bit6=a ... bit0=g.
- an  input  DIGITS  digit enables, active low; an[i]=0 selects digit i.
- bcd_out  output  4*DIGITS  published digits; digit i at bits [4i+3:4i].
- blank_mask  output  DIGITS  1 = digit i was blank in the published frame.
- frame_valid  output  1  one-cycle pulse when bcd_out/blank_mask update.
- frame_error  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (async, immediate): bcd_out=0, blank_mask=all ones, frame_valid=0, frame_error=0, seen=0, err=0, stability counter=0, FSM=COLLECT, input registers=all ones.
- Input stage: seg and an are registered once (seg_q, an_q). All decisions use the registered values.
- Stability:
  - cnt clears to 0 on any cycle where {an_q,seg_q} differs from its value on the previous cycle.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - An "accept" event fires on the cycle cnt transitions to STABLE_CYCLES-1 (for STABLE_CYCLES=1: every change cycle). It fires exactly once per dwell.
- Accept, an_q all ones: no action (inter-digit blanking).
- Accept, an_q has more than one zero: set err.
- Accept, an_q one-hot-low selecting index i:
  - Decode seg_q: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Legal digit: shadow[i]=value, shadow_blank[i]=0.
  - 1111111: shadow[i]=4'hF, shadow_blank[i]=1.
  - Any other pattern: set err, shadow[i]=4'hF, shadow_blank[i]=1.
  - Set seen[i]. A re-accept of an already-seen digit overwrites shadow[i]; the frame does not restart.
- FSM:
  - COLLECT -> PUBLISH on the cycle after seen becomes all ones.
  - PUBLISH lasts exactly one cycle:
    - err=0: copy shadow to bcd_out/blank_mask and pulse frame_valid.
    - err=1: outputs hold and frame_error pulses.
  - In both cases seen and err clear, and the FSM returns to COLLECT.
  - An accept landing in the PUBLISH cycle is applied to the new frame (seen set after the clear).
- Latency: frame_valid asserts 2 cycles after the accept of the last missing digit.
- Outputs are registered. frame_valid and frame_error are never high together.
- Mid-frame reset discards the partial frame. No output glitch on reset release.

Decomposition:
- Package seg7_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants (active-low abcdefg).
  - BCD_BLANK=4'hF.
  - A seg7_decode function returning {legal, blank, bcd}.
  - The same constants are shared with the encoder side.
- Sub-module seg_stability_filter (parameter WIDTH, STABLE_CYCLES):
  - Contains the input register, compare and counter.
  - Outputs the registered sample and an accept pulse.
- Frame assembly and FSM stay in the top.

Test Plan:
- DIGITS=4, STABLE_CYCLES=4. Scan an=1110/1101/1011/0111 with patterns for 1,2,3,4, each held 8 cycles. Expected: one frame_valid; bcd_out=16'h4321; blank_mask=0000.
- Same scan, but digit 2 held at 1111111. Expected: bcd_out=16'h4F21; blank_mask=0100; frame_valid pulses.
- Digit 1 pattern 1111110 (illegal). Expected: frame_error pulses; bcd_out keeps the previous frame value; the next clean frame pulses frame_valid.
- Digit 0 held only 3 cycles (shorter than STABLE_CYCLES) inside the scan. Expected: no accept; no pulse until a full dwell of digit 0 occurs.
- an=1100 (two digits on) held 8 cycles mid-frame. Expected: frame_error at frame completion. Separately, an=1111 gaps between digits cause no error.
- Assert rst after 2 digits are accepted, then release and send a full scan 9,8,7,6. Expected: outputs at reset values during rst; then a single frame_valid with bcd_out=16'h6789.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the pattern-to-BCD decoder.
// Segments are active low, abcdefg order (bit6=a ... bit0=g).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    ST_COLLECT,
    ST_PUBLISH
  } scan_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] bcd;
  } seg7_dec_t;

  // Blank is a legal pattern; anything unknown is illegal with bcd=F.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] s);
    seg7_dec_t d;
    d.legal = 1'b1;
    d.blank = 1'b0;
    d.bcd   = BCD_BLANK;
    case (s)
      SEG_0:     d.bcd = 4'd0;
      SEG_1:     d.bcd = 4'd1;
      SEG_2:     d.bcd = 4'd2;
      SEG_3:     d.bcd = 4'd3;
      SEG_4:     d.bcd = 4'd4;
      SEG_5:     d.bcd = 4'd5;
      SEG_6:     d.bcd = 4'd6;
      SEG_7:     d.bcd = 4'd7;
      SEG_8:     d.bcd = 4'd8;
      SEG_9:     d.bcd = 4'd9;
      SEG_BLANK: d.blank = 1'b1;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_stability_filter.sv
// Registers the bus once and fires one accept pulse per dwell
// once the sample has stayed unchanged long enough.
module seg_stability_filter #(
  parameter int WIDTH         = 11,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_accept
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CLAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_prev;
  logic [CW-1:0]    r_cnt;
  logic             w_diff;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_diff = (r_q != r_prev);

  // Count unchanged cycles, restart on any change, saturate.
  always_comb begin
    w_cnt_nxt = '0;
    if (!w_diff) begin
      w_cnt_nxt = (r_cnt == CMAX) ? CMAX : r_cnt + 1'b1;
    end
  end

  // Accept only on the transition into the last count.
  assign o_accept = (w_cnt_nxt == CLAST) &&
                    (w_diff || (r_cnt != CLAST));
  assign o_q = r_q;

  // Input sample, previous sample and dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '1;
      r_prev <= '1;
      r_cnt  <= '0;
    end else begin
      r_q    <= i_d;
      r_prev <= r_q;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and republishes
// each complete scan frame as BCD with a valid or error pulse.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  frame_valid,
  output logic                  frame_error
);

  logic [DIGITS+6:0]    w_sample;
  logic                 w_accept;
  logic [DIGITS-1:0]    w_an_sel;
  logic [6:0]           w_seg_q;
  logic                 w_none;
  logic                 w_onehot;
  logic                 w_multi;
  logic                 w_acc_dig;
  seg7_dec_t            w_dec;
  logic                 w_pub_go;
  logic [DIGITS-1:0]    w_seen_nxt;
  logic                 w_err_nxt;

  scan_state_e          r_state;
  scan_state_e          w_state_nxt;
  logic [DIGITS-1:0]    r_seen;
  logic                 r_err;
  logic [4*DIGITS-1:0]  r_shadow;
  logic [DIGITS-1:0]    r_shadow_blank;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [DIGITS-1:0]    r_blank;
  logic                 r_fv;
  logic                 r_fe;

  seg_stability_filter #(
    .WIDTH        (DIGITS + 7),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filt (
    .clk     (clk),
    .rst     (rst),
    .i_d     ({an, seg}),
    .o_q     (w_sample),
    .o_accept(w_accept)
  );

  assign w_an_sel  = ~w_sample[DIGITS+6:7];
  assign w_seg_q   = w_sample[6:0];
  assign w_dec     = seg7_decode(w_seg_q);
  assign w_none    = (w_an_sel == '0);
  assign w_onehot  = !w_none &&
                     ((w_an_sel & (w_an_sel - 1'b1)) == '0);
  assign w_multi   = !w_none && !w_onehot;
  assign w_acc_dig = w_accept && w_onehot;
  assign w_pub_go  = (r_state == ST_COLLECT) && (&r_seen);

  // Next-state: publish for one cycle once every digit is seen.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_pub_go) w_state_nxt = ST_PUBLISH;
      ST_PUBLISH: w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_COLLECT;
    else     r_state <= w_state_nxt;
  end

  // Frame bookkeeping; an accept during publish joins the new frame.
  always_comb begin
    w_seen_nxt = (r_state == ST_PUBLISH) ? '0 : r_seen;
    w_err_nxt  = (r_state == ST_PUBLISH) ? 1'b0 : r_err;
    if (w_acc_dig) begin
      w_seen_nxt = w_seen_nxt | w_an_sel;
      if (!w_dec.legal) w_err_nxt = 1'b1;
    end
    if (w_accept && w_multi) w_err_nxt = 1'b1;
  end

  // Seen/error flags and per-digit shadow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen         <= '0;
      r_err          <= 1'b0;
      r_shadow       <= '1;
      r_shadow_blank <= '1;
    end else begin
      r_seen <= w_seen_nxt;
      r_err  <= w_err_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_acc_dig && w_an_sel[i]) begin
          r_shadow[4*i +: 4] <= w_dec.bcd;
          r_shadow_blank[i]  <= w_dec.blank | ~w_dec.legal;
        end
      end
    end
  end

  // Registered outputs, pulses coincide with the publish cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd   <= '0;
      r_blank <= '1;
      r_fv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_fv <= w_pub_go && !r_err;
      r_fe <= w_pub_go && r_err;
      if (w_pub_go && !r_err) begin
        r_bcd   <= r_shadow;
        r_blank <= r_shadow_blank;
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign blank_mask  = r_blank;
  assign frame_valid = r_fv;
  assign frame_error = r_fe;

endmodule
